// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters:
//   requester 0 = execute stage, requester 1 = branch/address unit.
// Each requester offers a valid/ready channel with two operands and a 9-bit
// packed control word {op_sel[3:0], sub, bool_op[1:0], shift_dir, cmp_sig}.
// The winner's operands and control fields go straight to the ALU. The ALU
// result is captured at the same rising edge into a single registered
// response slot, tagged with the winner's ID.
//
// Parameters:
//   FIXED_PRIO : 0 = round-robin on conflicts, 1 = requester 0 always wins.
//   XLEN       : operand/result width.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_reqN_valid / o_reqN_ready    request handshake, N = 0/1
//   i_reqN_op_a, i_reqN_op_b       request operands
//   i_reqN_ctrl                    packed ALU control word
//   o_alu_op_a, o_alu_op_b         operands to the ALU
//   o_alu_op_sel                   one-hot unit select to the ALU
//   o_alu_sub, o_alu_shift_dir,
//   o_alu_cmp_sig, o_alu_bool_op   ALU control fields
//   i_alu_result                   combinational ALU result
//   o_rsp_valid, o_rsp_id,
//   o_rsp_result, i_rsp_ready      response slot handshake
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu_arbiter_chk
//
// Protocol checker bound inside alu_arbiter. Holds only single-cycle
// properties on the handshake and the ALU drive.
//
// Ports:
//   clk, rst_n                      clock and async active-low reset
//   req0_valid, req1_valid          request valids
//   req0_ready, req1_ready          request readies (grants)
//   rsp_valid, rsp_ready            response slot handshake
//   alu_op_sel                      unit select driven to the ALU
// ---------------------------------------------------------------------------
module alu_arbiter_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       req0_valid,
  input logic       req1_valid,
  input logic       req0_ready,
  input logic       req1_ready,
  input logic       rsp_valid,
  input logic       rsp_ready,
  input logic [3:0] alu_op_sel
);

  // Never grant both requesters in one cycle.
  a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));

  // A grant only goes to a requester that is asking.
  a_ready0_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
    req0_ready |-> req0_valid);

  a_ready1_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
    req1_ready |-> req1_valid);

  // A grant only happens when the slot is free or draining this cycle.
  a_grant_needs_room : assert property (@(posedge clk) disable iff (!rst_n)
    (req0_ready || req1_ready) |-> (!rsp_valid || rsp_ready));

  // Without a grant the ALU sees an all-zero unit select.
  a_idle_drive : assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready || req1_ready) |-> (alu_op_sel == 4'b0000));

endmodule

module alu_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned XLEN       = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,

  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [XLEN-1:0] i_req0_op_a,
  input  logic [XLEN-1:0] i_req0_op_b,
  input  logic [8:0]      i_req0_ctrl,

  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [XLEN-1:0] i_req1_op_a,
  input  logic [XLEN-1:0] i_req1_op_b,
  input  logic [8:0]      i_req1_ctrl,

  output logic [XLEN-1:0] o_alu_op_a,
  output logic [XLEN-1:0] o_alu_op_b,
  output logic [3:0]      o_alu_op_sel,
  output logic            o_alu_sub,
  output logic            o_alu_shift_dir,
  output logic            o_alu_cmp_sig,
  output logic [1:0]      o_alu_bool_op,
  input  logic [XLEN-1:0] i_alu_result,

  output logic            o_rsp_valid,
  output logic            o_rsp_id,
  output logic [XLEN-1:0] o_rsp_result,
  input  logic            i_rsp_ready
);

  // Field layout of the packed control word, MSB first.
  typedef struct packed {
    logic [3:0] op_sel;
    logic       sub;
    logic [1:0] bool_op;
    logic       shift_dir;
    logic       cmp_sig;
  } alu_ctrl_t;

  // Splits a raw control word into named fields.
  function automatic alu_ctrl_t unpack_ctrl(input logic [8:0] raw);
    return alu_ctrl_t'(raw);
  endfunction

  // Round-robin only exists when FIXED_PRIO is zero.
  localparam logic USE_RR = (FIXED_PRIO == 32'd0);

  logic            can_accept_s;
  logic            both_valid_s;
  logic            grant0_s;
  logic            grant1_s;
  logic            grant_any_s;
  alu_ctrl_t       ctrl0_s;
  alu_ctrl_t       ctrl1_s;

  logic            rsp_valid_r;
  logic            rsp_id_r;
  logic [XLEN-1:0] rsp_result_r;
  // Requester favoured on the next conflict.
  logic            rr_ptr_r;

  // The slot can take a new result if it is empty or drains this same edge,
  // which keeps one operation per cycle flowing under steady ready.
  assign can_accept_s = !rsp_valid_r || i_rsp_ready;
  assign both_valid_s = i_req0_valid && i_req1_valid;
  assign grant_any_s  = grant0_s || grant1_s;
  assign ctrl0_s      = unpack_ctrl(i_req0_ctrl);
  assign ctrl1_s      = unpack_ctrl(i_req1_ctrl);

  // Grant selection: sole requester wins outright; a conflict goes to the
  // round-robin pointer or to requester 0 under fixed priority. Readies stay
  // low while reset is asserted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (i_rst_n && can_accept_s) begin
      if (both_valid_s) begin
        if (!USE_RR) begin
          grant0_s = 1'b1;
        end else if (rr_ptr_r == 1'b0) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else begin
        grant0_s = i_req0_valid;
        grant1_s = i_req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // ALU drive mux: the granted requester's payload, or all zeros when idle
  // so the ALU sees no unit selected.
  always_comb begin
    o_alu_op_a      = {XLEN{1'b0}};
    o_alu_op_b      = {XLEN{1'b0}};
    o_alu_op_sel    = 4'b0000;
    o_alu_sub       = 1'b0;
    o_alu_bool_op   = 2'b00;
    o_alu_shift_dir = 1'b0;
    o_alu_cmp_sig   = 1'b0;
    if (grant1_s) begin
      o_alu_op_a      = i_req1_op_a;
      o_alu_op_b      = i_req1_op_b;
      o_alu_op_sel    = ctrl1_s.op_sel;
      o_alu_sub       = ctrl1_s.sub;
      o_alu_bool_op   = ctrl1_s.bool_op;
      o_alu_shift_dir = ctrl1_s.shift_dir;
      o_alu_cmp_sig   = ctrl1_s.cmp_sig;
    end else if (grant0_s) begin
      o_alu_op_a      = i_req0_op_a;
      o_alu_op_b      = i_req0_op_b;
      o_alu_op_sel    = ctrl0_s.op_sel;
      o_alu_sub       = ctrl0_s.sub;
      o_alu_bool_op   = ctrl0_s.bool_op;
      o_alu_shift_dir = ctrl0_s.shift_dir;
      o_alu_cmp_sig   = ctrl0_s.cmp_sig;
    end else begin
      o_alu_op_a      = {XLEN{1'b0}};
      o_alu_op_b      = {XLEN{1'b0}};
      o_alu_op_sel    = 4'b0000;
      o_alu_sub       = 1'b0;
      o_alu_bool_op   = 2'b00;
      o_alu_shift_dir = 1'b0;
      o_alu_cmp_sig   = 1'b0;
    end
  end

  // Response slot: capture on grant (a drain in the same edge is implicit),
  // clear on a drain without grant, otherwise hold. Id and result are left
  // untouched on a plain drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {XLEN{1'b0}};
    end else if (grant_any_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= grant1_s;
      rsp_result_r <= i_alu_result;
    end else if (rsp_valid_r && i_rsp_ready) begin
      rsp_valid_r  <= 1'b0;
    end
  end

  // Round-robin pointer: moves only on a conflict, to the loser, so a sole
  // requester never steals the next turn from the other side.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_r <= 1'b0;
    end else if (USE_RR && grant_any_s && both_valid_s) begin
      rr_ptr_r <= grant0_s;
    end
  end

  assign o_req0_ready = grant0_s;
  assign o_req1_ready = grant1_s;
  assign o_rsp_valid  = rsp_valid_r;
  assign o_rsp_id     = rsp_id_r;
  assign o_rsp_result = rsp_result_r;

  alu_arbiter_chk u_chk (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .req0_valid (i_req0_valid),
    .req1_valid (i_req1_valid),
    .req0_ready (grant0_s),
    .req1_ready (grant1_s),
    .rsp_valid  (rsp_valid_r),
    .rsp_ready  (i_rsp_ready),
    .alu_op_sel (o_alu_op_sel)
  );

endmodule
